// File: rtl/tmds_channel_decoder.sv
// TMDS receive lane: control-token symbol alignment (barrel window + slip FSM) and 10b->8b decode.
// Define TMDS_DEC_ERRCNT_EN to add the saturating lock_loss_cnt output.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic [9:0]  din,
    output logic [7:0]  vd,
    output logic [1:0]  cd,
    output logic        vde,
    output logic        locked,
    output logic [3:0]  offset
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    localparam int RUN_W   = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam int TMR_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [RUN_W-1:0]  run, run_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;
    logic [3:0]        offset_nxt;

    logic [9:0]  prev_p0;
    logic [19:0] cat_p0;
    logic [9:0]  win_p0;
    logic        is_tok_p0;
    logic [1:0]  tok_code_p0;

    logic [7:0]  vd_p1;
    logic [1:0]  cd_p1;
    logic        vde_p1;
    logic        locked_p1;

    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    // Stage 0: previous word capture and symbol window selection
    always_ff @(posedge pixclk) begin
        if (reset)
            prev_p0 <= '0;
        else
            prev_p0 <= din;
    end

    assign cat_p0 = {din, prev_p0};
    assign win_p0 = 10'(cat_p0 >> offset);

    always_comb begin
        is_tok_p0   = 1'b1;
        tok_code_p0 = 2'd0;
        case (win_p0)
            10'b1101010100: tok_code_p0 = 2'd0;
            10'b0010101011: tok_code_p0 = 2'd1;
            10'b0101010100: tok_code_p0 = 2'd2;
            10'b1010101011: tok_code_p0 = 2'd3;
            default:        is_tok_p0   = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        run_nxt    = run;
        timer_nxt  = timer;
        offset_nxt = offset;
        case (state)
            SEARCH: begin
                timer_nxt = timer + 1'b1;
                run_nxt   = is_tok_p0 ? run + 1'b1 : '0;
                // A lock and a timeout landing together resolve in favour of the lock.
                if (is_tok_p0 && run == RUN_W'(LOCK_COUNT - 1)) begin
                    state_nxt = LOCKED;
                    run_nxt   = '0;
                    timer_nxt = '0;
                end else if (timer == TMR_W'(SEARCH_TIMEOUT - 1)) begin
                    offset_nxt = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    run_nxt    = '0;
                    timer_nxt  = '0;
                end
            end
            LOCKED: begin
                timer_nxt = is_tok_p0 ? '0 : timer + 1'b1;
                if (!is_tok_p0 && timer == TMR_W'(LOSS_TIMEOUT - 1)) begin
                    state_nxt = SEARCH;
                    run_nxt   = '0;
                    timer_nxt = '0;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state  <= SEARCH;
            run    <= '0;
            timer  <= '0;
            offset <= '0;
        end else begin
            state  <= state_nxt;
            run    <= run_nxt;
            timer  <= timer_nxt;
            offset <= offset_nxt;
        end
    end

    // Stage 1: registered decode outputs, following the state being entered
    always_ff @(posedge pixclk) begin
        if (reset) begin
            vd_p1     <= '0;
            cd_p1     <= '0;
            vde_p1    <= 1'b0;
            locked_p1 <= 1'b0;
        end else if (state_nxt == LOCKED) begin
            locked_p1 <= 1'b1;
            if (is_tok_p0) begin
                vde_p1 <= 1'b0;
                vd_p1  <= '0;
                cd_p1  <= tok_code_p0;
            end else begin
                vde_p1 <= 1'b1;
                vd_p1  <= tmds_decode(win_p0);
            end
        end else begin
            vd_p1     <= '0;
            cd_p1     <= '0;
            vde_p1    <= 1'b0;
            locked_p1 <= 1'b0;
        end
    end

    assign vd     = vd_p1;
    assign cd     = cd_p1;
    assign vde    = vde_p1;
    assign locked = locked_p1;

`ifdef TMDS_DEC_ERRCNT_EN
    always_ff @(posedge pixclk) begin
        if (reset)
            lock_loss_cnt <= '0;
        else if (state == LOCKED && state_nxt == SEARCH && lock_loss_cnt != 16'hFFFF)
            lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: alignment search, decode table, lock loss, reset, offset wrap.
// With TMDS_DEC_ERRCNT_EN defined it also exercises lock_loss_cnt.
module tb_tmds_channel_decoder;

    localparam int LC = 8;
    localparam int ST = 2048;
    localparam int LT = 4096;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic [9:0]  din    = '0;
    logic [7:0]  vd;
    logic [1:0]  cd;
    logic        vde;
    logic        locked;
    logic [3:0]  offset;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0] w;
        logic [7:0] vd;
        logic [1:0] cd;
        logic       vde;
    } vec_t;

    vec_t vecs [11];

    tmds_channel_decoder #(
        .LOCK_COUNT    (LC),
        .SEARCH_TIMEOUT(ST),
        .LOSS_TIMEOUT  (LT)
    ) dut (
        .pixclk       (pixclk),
        .reset        (reset),
        .din          (din),
        .vd           (vd),
        .cd           (cd),
        .vde          (vde),
        .locked       (locked),
        .offset       (offset)
`ifdef TMDS_DEC_ERRCNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 pixclk = ~pixclk;

    task automatic tick(input int n);
        repeat (n) @(posedge pixclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] rotl3(input logic [9:0] t);
        return {t[6:0], t[9:7]};
    endfunction

    initial begin
        int  prev_off;
        int  steps;

        vecs[0]  = '{10'h100, 8'h00, 2'd0, 1'b1};
        vecs[1]  = '{10'h3FF, 8'h00, 2'd0, 1'b1};
        vecs[2]  = '{10'h200, 8'hFF, 2'd0, 1'b1};
        vecs[3]  = '{10'h0AB, 8'h00, 2'd1, 1'b0};
        vecs[4]  = '{10'h155, 8'hFF, 2'd1, 1'b1};
        vecs[5]  = '{10'h154, 8'h00, 2'd2, 1'b0};
        vecs[6]  = '{10'h10F, 8'h11, 2'd2, 1'b1};
        vecs[7]  = '{10'h2AB, 8'h00, 2'd3, 1'b0};
        vecs[8]  = '{10'h2F0, 8'hEF, 2'd3, 1'b1};
        vecs[9]  = '{10'h0AA, 8'h00, 2'd3, 1'b1};
        vecs[10] = '{10'h354, 8'h00, 2'd0, 1'b0};

        // Reset state, then token 00 arriving at bit offset 3
        reset = 1'b1;
        din   = rotl3(T00);
        tick(2);
        chk("rst_locked", locked, 0);
        chk("rst_offset", offset, 0);
        chk("rst_vde", vde, 0);
        chk("rst_vd", vd, 0);
        reset = 1'b0;
        prev_off = 0;
        steps    = 0;
        for (int c = 0; c < 3*ST + LC + 2; c++) begin
            tick(1);
            if (int'(offset) != prev_off) begin
                steps++;
                chk("t1_offset_step", offset, prev_off + 1);
                prev_off = int'(offset);
            end
            if (locked) break;
        end
        chk("t1_steps", steps, 3);
        chk("t1_locked", locked, 1);
        chk("t1_offset", offset, 3);
        chk("t1_cd", cd, 0);
        chk("t1_vde", vde, 0);

        // Token 11 at offset 3, then a single-cycle reset while locked
        din = rotl3(T11);
        tick(2);
        chk("t5_pre_cd", cd, 3);
        chk("t5_pre_locked", locked, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_locked", locked, 0);
        chk("t5_offset", offset, 0);
        chk("t5_vd", vd, 0);
        chk("t5_cd", cd, 0);
        chk("t5_vde", vde, 0);

        // Lock at offset 0, then the decode table
        din = T00;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (locked) break;
        end
        chk("t2_locked", locked, 1);
        chk("t2_offset", offset, 0);
        for (int i = 0; i < 11; i++) begin
            din = vecs[i].w;
            tick(2);
            chk($sformatf("vec%0d_vd", i), vd, vecs[i].vd);
            chk($sformatf("vec%0d_cd", i), cd, vecs[i].cd);
            chk($sformatf("vec%0d_vde", i), vde, vecs[i].vde);
            chk($sformatf("vec%0d_locked", i), locked, 1);
        end

        // Loss of lock after LT token-free windows, then relock
        din = 10'h100;
        tick(LT - 4);
        chk("t4_still_locked", locked, 1);
        tick(8);
        chk("t4_lost", locked, 0);
        chk("t4_vde", vde, 0);
        chk("t4_offset", offset, 0);
        din = T00;
        tick(LC);
        chk("t4_not_yet", locked, 0);
        tick(1);
        chk("t4_relock", locked, 1);
        chk("t4_relock_cd", cd, 0);

`ifdef TMDS_DEC_ERRCNT_EN
        chk("t6_cnt1", lock_loss_cnt, 1);
        for (int k = 0; k < 2; k++) begin
            din = 10'h100;
            tick(LT + 4);
            din = T00;
            tick(LC + 4);
        end
        chk("t6_cnt3", lock_loss_cnt, 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_cnt_rst", lock_loss_cnt, 0);
`endif

        // No tokens at all: offset walks 0..9 and wraps to 0
        reset = 1'b1;
        din   = 10'h000;
        tick(1);
        reset = 1'b0;
        tick(9*ST);
        chk("wrap_off9", offset, 9);
        tick(ST - 1);
        chk("wrap_off9_hold", offset, 9);
        tick(1);
        chk("wrap_off0", offset, 0);
        chk("wrap_locked", locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
